// File: rtl/bram_walk_ctrl.sv
// Dual-port BRAM fill/readback walker.
// Writes an address-derived pattern, reads it back, counts and reports errors.
module bram_walk_ctrl #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_a,
  output logic              we_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic [3:0]        nibble,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A  = ADDR_W'(2);

  function automatic logic [DATA_W-1:0] pat(
    input logic [ADDR_W-1:0] a
  );
    return {a, ~a, a, ~a, 8'hA5};
  endfunction

  state_t              r_state;
  logic [DATA_W-1:0]   r_data_a;
  logic [DATA_W-1:0]   r_data_b;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;
  logic                r_we;
  logic                r_rd;
  logic                r_rd_d;
  logic [ADDR_W-1:0]   r_exp_a;
  logic [ADDR_W-1:0]   r_exp_b;
  logic [3:0]          r_err;
  logic                r_found;
  logic [ADDR_W-1:0]   r_fail;
  logic                r_done;
  logic                r_pass;

  logic [ADDR_W-1:0]   w_nxt_a;
  logic [ADDR_W-1:0]   w_nxt_b;
  logic                w_miss_a;
  logic                w_miss_b;
  logic [4:0]          w_sum;
  logic [3:0]          w_err_nxt;

  assign w_nxt_a  = r_addr_a + TWO_A;
  assign w_nxt_b  = r_addr_b + TWO_A;

  // readback compare against the address presented one cycle earlier
  always_comb begin
    w_miss_a  = r_rd_d && (q_a != pat(r_exp_a));
    w_miss_b  = r_rd_d && (q_b != pat(r_exp_b));
    w_sum     = {1'b0, r_err}
              + {4'b0, w_miss_a}
              + {4'b0, w_miss_b};
    w_err_nxt = w_sum[4] ? 4'hF : w_sum[3:0];
  end

  // sequencer FSM, address pipeline and error accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_data_a <= '0;
      r_data_b <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_we     <= 1'b0;
      r_rd     <= 1'b0;
      r_rd_d   <= 1'b0;
      r_exp_a  <= '0;
      r_exp_b  <= '0;
      r_err    <= '0;
      r_found  <= 1'b0;
      r_fail   <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_rd_d  <= r_rd;
      r_exp_a <= r_addr_a;
      r_exp_b <= r_addr_b;
      if (r_rd_d) begin
        r_err <= w_err_nxt;
        if (!r_found && (w_miss_a || w_miss_b)) begin
          r_found <= 1'b1;
          r_fail  <= w_miss_a ? r_exp_a : r_exp_b;
        end
      end
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_WRITE;
            r_addr_a <= '0;
            r_addr_b <= ONE_A;
            r_data_a <= pat('0);
            r_data_b <= pat(ONE_A);
            r_we     <= 1'b1;
            r_err    <= '0;
            r_found  <= 1'b0;
            r_fail   <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
          end
        end
        S_WRITE: begin
          if (r_addr_a == LAST_A) begin
            r_state  <= S_READ;
            r_addr_a <= '0;
            r_addr_b <= ONE_A;
            r_data_a <= '0;
            r_data_b <= '0;
            r_we     <= 1'b0;
            r_rd     <= 1'b1;
          end else begin
            r_addr_a <= w_nxt_a;
            r_addr_b <= w_nxt_b;
            r_data_a <= pat(w_nxt_a);
            r_data_b <= pat(w_nxt_b);
          end
        end
        S_READ: begin
          if (r_addr_a == LAST_A) begin
            r_state <= S_CHECK;
            r_rd    <= 1'b0;
          end else begin
            r_addr_a <= w_nxt_a;
            r_addr_b <= w_nxt_b;
          end
        end
        S_CHECK: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_pass  <= (w_err_nxt == 4'd0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_a    = r_data_a;
  assign data_b    = r_data_b;
  assign addr_a    = r_addr_a;
  assign addr_b    = r_addr_b;
  assign we_a      = r_we;
  assign we_b      = r_we;
  assign nibble    = r_err;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_addr = r_fail;

endmodule

// File: tb/tb_bram_walk_ctrl.sv
// Bench for bram_walk_ctrl with a 16-word registered BRAM model.
// Expected DONE results are queued at stimulus time and popped by a monitor.
module tb_bram_walk_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [47:0] data_a, data_b, q_a, q_b;
  logic [9:0]  addr_a, addr_b, fail_addr;
  logic        we_a, we_b, done, pass;
  logic [3:0]  nibble;

  typedef struct {
    logic [3:0] nib;
    logic [9:0] fa;
    logic       ps;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [47:0] mem [16];
  bit   [15:0] corr = '0;
  logic        done_q = 1'b0;

  always #5 clk = ~clk;

  bram_walk_ctrl #(.DATA_W(48), .ADDR_W(10), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_a(data_a), .data_b(data_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .we_a(we_a), .we_b(we_b),
    .q_a(q_a), .q_b(q_b),
    .nibble(nibble), .done(done), .pass(pass),
    .fail_addr(fail_addr)
  );

  always @(posedge clk) begin
    if (we_a === 1'b1) mem[addr_a[3:0]] <= data_a;
    if (we_b === 1'b1) mem[addr_b[3:0]] <= data_b;
    q_a <= mem[addr_a[3:0]] ^ {47'b0, corr[addr_a[3:0]]};
    q_b <= mem[addr_b[3:0]] ^ {47'b0, corr[addr_b[3:0]]};
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_nibble", {60'b0, nibble}, {60'b0, e.nib});
        chk("done_fail_addr", {54'b0, fail_addr}, {54'b0, e.fa});
        chk("done_pass", {63'b0, pass}, {63'b0, e.ps});
      end
    end
    done_q = done;
  end

  task automatic push(input logic [3:0] nib,
                      input logic [9:0] fa,
                      input logic ps);
    exp_t e;
    e.nib = nib;
    e.fa  = fa;
    e.ps  = ps;
    sb.push_back(e);
  endtask

  task automatic measure(input bit drop,
                         output int wec, output int wf,
                         output int wl, output int dcyc,
                         output logic d1,
                         output logic [9:0] a2,
                         output logic [47:0] d2);
    @(posedge clk);
    #1;
    if (drop) start = 1'b0;
    wec = 0; wf = -1; wl = -1; dcyc = -1;
    d1 = done; a2 = '0; d2 = '0;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) begin
        @(posedge clk);
        #1;
      end
      if (j == 2) begin
        a2 = addr_a;
        d2 = data_a;
      end
      if (we_a === 1'b1 && we_b === 1'b1) begin
        wec++;
        if (wf < 0) wf = j;
        wl = j;
      end
      if (done === 1'b1) begin
        dcyc = j;
        break;
      end
    end
  endtask

  initial begin
    int          wec, wf, wl, dcyc, act;
    logic        d1;
    logic [9:0]  a2;
    logic [47:0] d2;
    logic [47:0] exp_d2;
    exp_d2 = {10'h002, 10'h3FD, 10'h002, 10'h3FD, 8'hA5};

    reset = 1'b1;
    repeat (2) begin
      start = 1'($urandom % 2);
      @(posedge clk);
      #1;
    end
    chk("rst_we", {62'b0, we_a, we_b}, 64'd0);
    chk("rst_addr", {44'b0, addr_a, addr_b}, 64'd0);
    chk("rst_data", {16'b0, data_a | data_b}, 64'd0);
    chk("rst_status", {48'b0, nibble, done, pass, fail_addr}, 64'd0);
    reset = 1'b0;
    start = 1'b0;
    act = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (we_a !== 1'b0 || we_b !== 1'b0) act++;
    end
    chk("idle_we_low", 64'(act), 64'd0);

    push(4'd0, 10'd0, 1'b1);
    start = 1'b1;
    measure(1'b1, wec, wf, wl, dcyc, d1, a2, d2);
    chk("clean_we_first", 64'(wf), 64'd1);
    chk("clean_we_last", 64'(wl), 64'd8);
    chk("clean_we_count", 64'(wec), 64'd8);
    chk("clean_addr2", {54'b0, a2}, 64'd2);
    chk("clean_data2", {16'b0, d2}, {16'b0, exp_d2});
    chk("clean_done_cyc", 64'(dcyc), 64'd18);
    repeat (3) @(posedge clk);
    #1;

    corr = 16'h0020;
    push(4'd1, 10'd5, 1'b0);
    start = 1'b1;
    measure(1'b1, wec, wf, wl, dcyc, d1, a2, d2);
    chk("single_done_cyc", 64'(dcyc), 64'd18);
    chk("single_done_drop", {63'b0, d1}, 64'd0);

    corr = 16'h00C0;
    push(4'd2, 10'd6, 1'b0);
    start = 1'b1;
    measure(1'b1, wec, wf, wl, dcyc, d1, a2, d2);
    chk("dual_done_cyc", 64'(dcyc), 64'd18);

    corr = 16'hFFFF;
    push(4'd15, 10'd0, 1'b0);
    start = 1'b1;
    measure(1'b1, wec, wf, wl, dcyc, d1, a2, d2);
    chk("sat_done_cyc", 64'(dcyc), 64'd18);
    repeat (4) @(posedge clk);
    #1;

    corr = '0;
    push(4'd0, 10'd0, 1'b1);
    start = 1'b1;
    measure(1'b1, wec, wf, wl, dcyc, d1, a2, d2);
    chk("restart_done_drop", {63'b0, d1}, 64'd0);
    chk("restart_we_count", 64'(wec), 64'd8);
    chk("restart_done_cyc", 64'(dcyc), 64'd18);

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_we", {62'b0, we_a, we_b}, 64'd0);
    chk("midrst_addr", {44'b0, addr_a, addr_b}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    act = 0;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (we_a !== 1'b0 || addr_a !== '0 || addr_b !== '0) act++;
    end
    chk("midrst_quiet", 64'(act), 64'd0);

    push(4'd0, 10'd0, 1'b1);
    push(4'd0, 10'd0, 1'b1);
    start = 1'b1;
    measure(1'b0, wec, wf, wl, dcyc, d1, a2, d2);
    chk("held_we_count", 64'(wec), 64'd8);
    chk("held_done_cyc", 64'(dcyc), 64'd18);
    measure(1'b0, wec, wf, wl, dcyc, d1, a2, d2);
    start = 1'b0;
    chk("held2_done_drop", {63'b0, d1}, 64'd0);
    chk("held2_we_count", 64'(wec), 64'd8);
    chk("held2_done_cyc", 64'(dcyc), 64'd18);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bram_walk_ctrl.md
Name: bram_walk_ctrl

Overview:
- Upstream sequencer for the 48-bit, 1024-deep dual-port BRAM. It drives both BRAM ports and produces a 4-bit nibble for the hex 7-segment decoder.
- On a start request it fills the BRAM with an address-derived pattern using both ports (two words per cycle). It then reads every word back and compares it against the expected value.
- Reports pass/fail, a saturating error count (the value shown on the display) and the first failing address.

Parameters:
- DATA_W, 48, BRAM word width; fixed by pattern format, only 48 supported.
- ADDR_W, 10, BRAM address width.
- DEPTH, 1024, words exercised; must be even and ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled only in IDLE and DONE.
- data_a  out  48  port A write data.
- data_b  out  48  port B write data.
- addr_a  out  10  port A address.
- addr_b  out  10  port B address.
- we_a  out  1  port A write enable.
- we_b  out  1  port B write enable.
- q_a  in  48  port A read data; registered BRAM, valid 1 cycle after address.
- q_b  in  48  port B read data; same timing.
- nibble  out  4  err_count[3:0], drives the hex decoder.
- done  out  1  test complete.
- pass  out  1  done and zero errors.
- fail_addr  out  10  first mismatching address; 0 if none.

Behaviour:
- One clock domain (clk). reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; data_a, data_b, addr_a, addr_b all 0; we_a=we_b=0; nibble=0; done=0; pass=0; fail_addr=0.
- Pattern: P(a) = {a, ~a, a, ~a, 8'hA5}, with a being 10 bits; 10+10+10+10+8 = 48 bits.
- States: IDLE, WRITE, READ, CHECK, DONE.
- Timing is measured from edge N, the edge where start=1 is sampled in IDLE.
- IDLE:
  - we=0.
  - On start: clear err_count, fail_addr, done, pass; go to WRITE with pair index k=0.
- WRITE, cycles N+1 .. N+DEPTH/2:
  - addr_a=2k, addr_b=2k+1, data_a=P(2k), data_b=P(2k+1), we_a=we_b=1; k increments each cycle.
  - After k=DEPTH/2-1: go to READ, reset k to 0.
- READ, cycles N+DEPTH/2+1 .. N+DEPTH:
  - we=0; addr_a=2k, addr_b=2k+1; data outputs hold 0.
  - Expected addresses are delayed one cycle.
  - From the second READ cycle on, compare q_a against P(delayed addr_a) and q_b against P(delayed addr_b).
- CHECK, one cycle (N+DEPTH+1):
  - we=0; compare the final pair; go to DONE.
- DONE, from N+DEPTH+2:
  - done=1; pass=(err_count==0); outputs held.
  - start=1 restarts exactly as from IDLE: done drops the next cycle; err_count and fail_addr are cleared.
- Error accounting:
  - Each mismatching word increments err_count by 1, so 0, 1 or 2 per cycle.
  - err_count is 4 bits and saturates at 15; a +2 from 14 gives 15.
- fail_addr:
  - Captured on the first mismatch only.
  - If both ports mismatch in the same cycle, the port A address (the lower one) wins.
- nibble tracks err_count live during READ and CHECK.
- start outside IDLE and DONE is ignored.
- Reset in any state: the next edge gives reset values; we drops immediately; a partial fill is abandoned.
- Writes and reads never overlap, so there is no read-during-write hazard.
- Address counters never exceed DEPTH-1; there is no wrap.

Test Plan:
- Reset: hold reset 2 cycles with random inputs → all outputs 0, state IDLE; start held low → we stays 0 forever.
- Clean run (DEPTH=16, ideal BRAM model):
  - start pulse at edge N → we_a=we_b=1 for exactly cycles N+1..N+8.
  - At N+2: addr_a=2, data_a={10'h002,10'h3FD,10'h002,10'h3FD,8'hA5}.
  - done=1 and pass=1 at N+18; nibble=0.
- Single fault: model flips q_b bit 0 at address 5 → at DONE err_count=1, nibble=1, fail_addr=5, pass=0.
- Dual fault and saturation:
  - Corrupt addresses 6 and 7 → err_count=2, fail_addr=6.
  - Corrupt all 16 addresses → nibble=15, fail_addr=0.
- Reset mid-operation: assert reset at N+4 during WRITE → we=0 from N+5; IDLE; no further address activity until the next start.
- Start handling:
  - start held high through the whole run → no restart before DONE.
  - In DONE, start pulse → done=0 next cycle, err_count cleared, full sequence repeats; done again 18 cycles after the restart edge.
